usb_in_ep_stream: RTL and testbench

Byte-stream-to-IN-endpoint packetiser. Accepts bytes from application logic into an internal FIFO and, through the USB protocol engine's IN endpoint interface (req/grant, put, done, acked), transfers them as packets of up to MAX_PKT bytes. Partial packets are flushed after an SOF-counted timeout. A zero-length packet terminates any transfer whose last packet was exactly MAX_PKT bytes. One instance serves one IN endpoint; its bus bits connect to one slot of the protocol engine's in_ep_* vectors.

---
 rtl/usb_in_ep_stream.sv | 138 +++++++++++++
 tb/tb_usb_in_ep_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_ep_stream.sv
// Byte-stream to USB IN endpoint packetiser: FIFO buffering, MAX_PKT packetisation,
// SOF-timed flush of short packets and ZLP termination of full-sized transfers.
module usb_in_ep_stream #(
  parameter int unsigned DEPTH_LOG2   = 7,
  parameter int unsigned MAX_PKT      = 64,
  parameter int unsigned TIMEOUT_SOFS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  halt,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  sof_valid,
  output logic                  in_ep_req,
  input  logic                  in_ep_grant,
  input  logic                  in_ep_data_free,
  output logic                  in_ep_data_put,
  output logic [7:0]            in_ep_data,
  output logic                  in_ep_data_done,
  output logic                  in_ep_stall,
  input  logic                  in_ep_acked
);

  localparam int unsigned    CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]  DEPTH = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0]  MAXC  = CW'(MAX_PKT);
  localparam logic [3:0]     TMO   = 4'(TIMEOUT_SOFS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_FILL     = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;

  logic [7:0]            mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, pkt_len_q, pkt_len_d, sent_q, sent_d;
  logic [3:0]            sof_cnt_q, sof_cnt_d;
  logic                  zlp_pend_q, zlp_pend_d;
  logic [2:0]            state_q, state_d;
  logic                  push, pop, start;

  assign wr_ready        = (count_q != DEPTH);
  assign level           = count_q;
  assign in_ep_req       = (state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_DONE);
  assign in_ep_data_put  = (state_q == S_FILL) && (sent_q != pkt_len_q);
  assign in_ep_data      = mem_q[rd_ptr_q];
  assign in_ep_data_done = (state_q == S_DONE);
  assign in_ep_stall     = halt;

  assign push  = wr_valid && wr_ready;
  assign pop   = in_ep_data_put;
  assign start = !halt && in_ep_data_free &&
                 ((count_q >= MAXC) || ((count_q != '0) && (sof_cnt_q >= TMO)) || zlp_pend_q);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    pkt_len_d  = pkt_len_q;
    sent_d     = sent_q;
    sof_cnt_d  = sof_cnt_q;
    zlp_pend_d = zlp_pend_q;
    state_d    = state_q;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (count_q == '0)
      sof_cnt_d = '0;
    else if (sof_valid && (state_q == S_IDLE) && (count_q < MAXC) && (sof_cnt_q != 4'hF))
      sof_cnt_d = sof_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // Flush overrides both a same-cycle push and a packet start.
        if (flush) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          sof_cnt_d  = '0;
          zlp_pend_d = 1'b0;
        end else if (start) begin
          state_d   = S_REQ;
          sof_cnt_d = '0;
          sent_d    = '0;
          // A pending ZLP goes first so the previous transfer terminates cleanly.
          pkt_len_d = zlp_pend_q ? '0 : ((count_q >= MAXC) ? MAXC : count_q);
        end
      end
      S_REQ: if (in_ep_grant) state_d = S_FILL;
      S_FILL: begin
        if (sent_q == pkt_len_q) begin
          state_d = S_DONE;
        end else begin
          sent_d = sent_q + 1'b1;
          if (sent_q + 1'b1 == pkt_len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        zlp_pend_d = (pkt_len_q == MAXC) && (count_q == '0);
        state_d    = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (in_ep_acked) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_len_q  <= '0;
      sent_q     <= '0;
      sof_cnt_q  <= '0;
      zlp_pend_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_len_q  <= pkt_len_d;
      sent_q     <= sent_d;
      sof_cnt_q  <= sof_cnt_d;
      zlp_pend_q <= zlp_pend_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_usb_in_ep_stream.sv
// Directed bench for usb_in_ep_stream: a simple engine model grants/acks, an
// in-order byte scoreboard checks every put, and packet lengths/timing are checked.
module tb_usb_in_ep_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready, halt, flush, sof_valid;
  logic [7:0] level;
  logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done, in_ep_stall, in_ep_acked;

  usb_in_ep_stream #(.DEPTH_LOG2(7), .MAX_PKT(64), .TIMEOUT_SOFS(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .halt(halt), .flush(flush), .level(level),
    .sof_valid(sof_valid), .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, reqs = 0, dones = 0, cur_len = 0, last_len = 0;
  int grant_cyc = 0, done_cyc = 0, first_put_cyc = 0, src_rem = 0;
  logic [7:0] src_byte = 8'h00, exp_rd = 8'h00;
  logic req_prev = 1'b0, gave = 1'b0, ack_pend = 1'b0, auto_grant = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs at negedge, then drive the engine model and byte source.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (in_ep_data_put) begin
      if (cur_len == 0) first_put_cyc = cyc;
      chk("put_data", int'(in_ep_data), int'(exp_rd));
      exp_rd++;
      cur_len++;
    end
    if (in_ep_req && !req_prev) reqs++;
    req_prev = in_ep_req;
    if (in_ep_data_done) begin
      dones++;
      last_len = cur_len;
      cur_len  = 0;
      done_cyc = cyc;
    end
    in_ep_acked = ack_pend;
    ack_pend    = in_ep_data_done;
    if (!in_ep_req) gave = 1'b0;
    in_ep_grant = 1'b0;
    if (auto_grant && in_ep_req && !gave) begin
      in_ep_grant = 1'b1;
      gave        = 1'b1;
      grant_cyc   = cyc;
    end
    wr_valid = (src_rem > 0);
    wr_data  = src_byte;
    if (wr_valid && wr_ready) begin
      src_byte++;
      src_rem--;
    end
  endtask

  task automatic sof_pulse();
    sof_valid = 1'b1;
    step();
    sof_valid = 1'b0;
  endtask

  task automatic wait_dones(int target, int limit, string tag);
    int n = 0;
    while (dones < target && n < limit) begin
      step();
      n++;
    end
    chk(tag, dones, target);
  endtask

  initial begin
    int n, r0, d0;
    reset_n = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; halt = 1'b0; flush = 1'b0;
    sof_valid = 1'b0; in_ep_grant = 1'b0; in_ep_data_free = 1'b1; in_ep_acked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_req", in_ep_req, 0);
    chk("rst_put", in_ep_data_put, 0);
    chk("rst_done", in_ep_data_done, 0);
    chk("rst_stall", in_ep_stall, 0);
    reset_n = 1'b1;

    // Full 64-byte packet followed by a ZLP
    auto_grant = 1'b1;
    src_rem = 64;
    n = 0;
    while (level != 8'd64 && n < 200) begin step(); n++; end
    chk("t1_level64", level, 64);
    step();
    chk("t1_start_latency", in_ep_req, 1);
    wait_dones(1, 200, "t1_pkt_done");
    chk("t1_pkt_len", last_len, 64);
    chk("t1_first_put", first_put_cyc, grant_cyc + 1);
    chk("t1_grant_to_done", done_cyc - grant_cyc, 65);
    wait_dones(2, 50, "t1_zlp_done");
    chk("t1_zlp_len", last_len, 0);
    chk("t1_zlp_time", done_cyc - grant_cyc, 2);
    repeat (20) step();
    chk("t1_no_extra_req", reqs, 2);

    // Short packet after the SOF timeout
    r0 = reqs; d0 = dones;
    src_rem = 5;
    repeat (10) step();
    chk("t2_level5", level, 5);
    chk("t2_no_req_0sof", reqs, r0);
    sof_pulse();
    repeat (10) step();
    chk("t2_no_req_1sof", reqs, r0);
    sof_pulse();
    wait_dones(d0 + 1, 40, "t2_pkt_done");
    chk("t2_pkt_len", last_len, 5);
    repeat (10) step();
    chk("t2_no_zlp", reqs, r0 + 1);

    // FIFO fill to 128 then streaming with concurrent push/pop
    r0 = reqs; d0 = dones;
    auto_grant = 1'b0;
    src_rem = 130;
    n = 0;
    while (wr_ready && n < 300) begin step(); n++; end
    chk("t3_full_level", level, 128);
    chk("t3_full_wr_ready", wr_ready, 0);
    chk("t3_src_left", src_rem, 2);
    chk("t3_req_held", in_ep_req, 1);
    auto_grant = 1'b1;
    wait_dones(d0 + 1, 200, "t3_pkt1_done");
    chk("t3_pkt1_len", last_len, 64);
    wait_dones(d0 + 2, 200, "t3_pkt2_done");
    chk("t3_pkt2_len", last_len, 64);
    chk("t3_src_drained", src_rem, 0);
    chk("t3_level2", level, 2);
    repeat (10) step();
    chk("t3_no_req_yet", reqs, r0 + 2);
    sof_pulse();
    sof_pulse();
    wait_dones(d0 + 3, 40, "t3_pkt3_done");
    chk("t3_pkt3_len", last_len, 2);
    repeat (20) step();
    chk("t3_no_zlp", reqs, r0 + 3);
    chk("t3_level0", level, 0);

    // Halt blocks new packets
    r0 = reqs; d0 = dones;
    halt = 1'b1;
    #1 chk("t4_stall_on", in_ep_stall, 1);
    src_rem = 64;
    repeat (90) step();
    chk("t4_level64", level, 64);
    chk("t4_no_req", reqs, r0);
    halt = 1'b0;
    #1 chk("t4_stall_off", in_ep_stall, 0);
    wait_dones(d0 + 1, 200, "t4_pkt_done");
    chk("t4_pkt_len", last_len, 64);
    wait_dones(d0 + 2, 50, "t4_zlp_done");
    chk("t4_zlp_len", last_len, 0);

    // Flush in IDLE discards; flush during FILL is ignored
    r0 = reqs; d0 = dones;
    src_rem = 40;
    repeat (45) step();
    chk("t5_level40", level, 40);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_rd = src_byte;
    chk("t5_flushed_level", level, 0);
    sof_pulse();
    sof_pulse();
    repeat (10) step();
    chk("t5_no_pkt", reqs, r0);
    src_rem = 64;
    n = 0;
    while (cur_len == 0 && n < 200) begin step(); n++; end
    chk("t5_fill_started", in_ep_data_put, 1);
    flush = 1'b1;
    n = 0;
    while (dones < d0 + 1 && n < 200) begin
      step();
      if (level == 8'd0) flush = 1'b0;
      n++;
    end
    flush = 1'b0;
    chk("t5_fill_done", dones, d0 + 1);
    chk("t5_fill_len", last_len, 64);
    wait_dones(d0 + 2, 50, "t5_zlp_done");
    chk("t5_zlp_len", last_len, 0);

    // Reset in the middle of FILL
    d0 = dones;
    src_rem = 64;
    n = 0;
    while (cur_len != 10 && n < 200) begin step(); n++; end
    chk("t6_ten_puts", cur_len, 10);
    reset_n = 1'b0;
    #1;
    chk("t6_req_low", in_ep_req, 0);
    chk("t6_put_low", in_ep_data_put, 0);
    chk("t6_done_low", in_ep_data_done, 0);
    chk("t6_level0", level, 0);
    chk("t6_wr_ready", wr_ready, 1);
    cur_len = 0; gave = 1'b0; ack_pend = 1'b0; src_rem = 0;
    in_ep_grant = 1'b0; in_ep_acked = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    exp_rd = src_byte;
    src_rem = 3;
    repeat (6) step();
    chk("t6_level3", level, 3);
    sof_pulse();
    sof_pulse();
    wait_dones(d0 + 1, 40, "t6_recover_done");
    chk("t6_recover_len", last_len, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
